// File: rtl/wb_stage.sv
// Writeback stage: takes retiring packets from MEM, waits for load data, and issues one register write.
// Optional build macro WB_RETIRE_CNT_EN adds a 64-bit retire counter output (retire_cnt_o).
module wb_stage #(
   parameter int unsigned LOAD_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        mem_valid_i,
   output logic        mem_ready_o,
   input  logic [4:0]  mem_rd_i,
   input  logic        mem_regwrite_i,
   input  logic [1:0]  mem_wbsel_i,
   input  logic [31:0] mem_alu_i,
   input  logic [31:0] mem_pc4_i,
   input  logic [2:0]  mem_funct3_i,
   input  logic [1:0]  mem_addr_lo_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        regwrite_o,
   output logic [4:0]  rd_o,
   output logic [31:0] wd_o,
   output logic        err_o
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [63:0] retire_cnt_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   localparam logic [15:0] CNT_LAST = 16'(LOAD_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  pkt_rd_q, pkt_rd_d;
   logic        pkt_we_q, pkt_we_d;
   logic [2:0]  pkt_f3_q, pkt_f3_d;
   logic [1:0]  pkt_alo_q, pkt_alo_d;
   logic        ready_q, ready_d;
   logic        regwrite_q, regwrite_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] wd_q, wd_d;
   logic        err_q, err_d;
   logic        accept_s;

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = w[7:0];
      endcase
      // Halfword select ignores addr bit 0: misaligned halves are not trapped.
      h = lo[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b100:  fmt_load = {24'd0, b};
         3'b101:  fmt_load = {16'd0, h};
         default: fmt_load = w;
      endcase
   endfunction

   assign accept_s = mem_valid_i & ready_q;

   // Next-state, packet capture and registered-output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pkt_rd_d   = pkt_rd_q;
      pkt_we_d   = pkt_we_q;
      pkt_f3_d   = pkt_f3_q;
      pkt_alo_d  = pkt_alo_q;
      regwrite_d = 1'b0;
      rd_d       = rd_q;
      wd_d       = wd_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE, S_WRITE: begin
            if (accept_s) begin
               pkt_rd_d  = mem_rd_i;
               pkt_we_d  = mem_regwrite_i;
               pkt_f3_d  = mem_funct3_i;
               pkt_alo_d = mem_addr_lo_i;
               if (mem_wbsel_i == 2'b01) begin
                  state_d = S_WAIT;
                  cnt_d   = 16'd0;
               end else begin
                  state_d    = S_WRITE;
                  regwrite_d = mem_regwrite_i & (mem_rd_i != 5'd0);
                  rd_d       = mem_rd_i;
                  wd_d       = (mem_wbsel_i == 2'b10) ? mem_pc4_i : mem_alu_i;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            // A response on the final count still wins over the timeout.
            if (dmem_rvalid_i) begin
               state_d    = S_WRITE;
               regwrite_d = pkt_we_q & (pkt_rd_q != 5'd0);
               rd_d       = pkt_rd_q;
               wd_d       = fmt_load(pkt_f3_q, pkt_alo_q, dmem_rdata_i);
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d != S_WAIT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         pkt_rd_q   <= 5'd0;
         pkt_we_q   <= 1'b0;
         pkt_f3_q   <= 3'd0;
         pkt_alo_q  <= 2'd0;
         ready_q    <= 1'b0;
         regwrite_q <= 1'b0;
         rd_q       <= 5'd0;
         wd_q       <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pkt_rd_q   <= pkt_rd_d;
         pkt_we_q   <= pkt_we_d;
         pkt_f3_q   <= pkt_f3_d;
         pkt_alo_q  <= pkt_alo_d;
         ready_q    <= ready_d;
         regwrite_q <= regwrite_d;
         rd_q       <= rd_d;
         wd_q       <= wd_d;
         err_q      <= err_d;
      end
   end

   assign mem_ready_o = ready_q;
   assign regwrite_o  = regwrite_q;
   assign rd_o        = rd_q;
   assign wd_o        = wd_q;
   assign err_o       = err_q;

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt_q, retire_cnt_d;

   // Every WRITE-state cycle retires one instruction, including rd=0 and non-writing ones.
   always_comb begin
      if (state_q == S_WRITE) begin
         retire_cnt_d = retire_cnt_q + 64'd1;
      end else begin
         retire_cnt_d = retire_cnt_q;
      end
   end

   // Retire counter register.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         retire_cnt_q <= 64'd0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected register writes plus per-scenario checks.
module tb_wb_stage;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        mem_valid_i;
   logic        mem_ready_o;
   logic [4:0]  mem_rd_i;
   logic        mem_regwrite_i;
   logic [1:0]  mem_wbsel_i;
   logic [31:0] mem_alu_i;
   logic [31:0] mem_pc4_i;
   logic [2:0]  mem_funct3_i;
   logic [1:0]  mem_addr_lo_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        regwrite_o;
   logic [4:0]  rd_o;
   logic [31:0] wd_o;
   logic        err_o;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt_o;
`endif

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] wd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   wb_stage #(.LOAD_TIMEOUT(4)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .mem_valid_i    (mem_valid_i),
      .mem_ready_o    (mem_ready_o),
      .mem_rd_i       (mem_rd_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_wbsel_i    (mem_wbsel_i),
      .mem_alu_i      (mem_alu_i),
      .mem_pc4_i      (mem_pc4_i),
      .mem_funct3_i   (mem_funct3_i),
      .mem_addr_lo_i  (mem_addr_lo_i),
      .dmem_rvalid_i  (dmem_rvalid_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .regwrite_o     (regwrite_o),
      .rd_o           (rd_o),
      .wd_o           (wd_o),
      .err_o          (err_o)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_cnt_o   (retire_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard monitor: every register-write pulse must match the oldest expected write.
   always @(negedge clk_i) begin
      if (regwrite_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_write: got rd=%0d wd=%h, required no write", rd_o, wd_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (rd_o !== e.rd || wd_o !== e.wd) begin
               errors++;
               $display("FAIL sb_write: got rd=%0d wd=%h, required rd=%0d wd=%h", rd_o, wd_o, e.rd, e.wd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      mem_valid_i    = 1'b0;
      mem_rd_i       = 5'd0;
      mem_regwrite_i = 1'b0;
      mem_wbsel_i    = 2'b00;
      mem_alu_i      = 32'd0;
      mem_pc4_i      = 32'd0;
      mem_funct3_i   = 3'd0;
      mem_addr_lo_i  = 2'd0;
      dmem_rvalid_i  = 1'b0;
      dmem_rdata_i   = 32'd0;
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      idle_inputs();
      step();
      step();
      checks++;
      if ({regwrite_o, rd_o, wd_o, err_o, mem_ready_o} !== 40'd0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b rd=%0d wd=%h err=%b rdy=%b, required all 0",
                  regwrite_o, rd_o, wd_o, err_o, mem_ready_o);
      end
`ifdef WB_RETIRE_CNT_EN
      checks++;
      if (retire_cnt_o !== 64'd0) begin
         errors++;
         $display("FAIL reset_retire: got %0d, required 0", retire_cnt_o);
      end
`endif
      reset_i = 1'b1;
      step();
      checks++;
      if (mem_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_rise: got %b, required 1", mem_ready_o);
      end
   endtask

   task automatic test_alu();
      mem_valid_i    = 1'b1;
      mem_wbsel_i    = 2'b00;
      mem_rd_i       = 5'd5;
      mem_regwrite_i = 1'b1;
      mem_alu_i      = 32'h1234_5678;
      mem_pc4_i      = 32'h0000_0abc;
      exp_q.push_back('{5'd5, 32'h1234_5678});
      step();
      mem_valid_i = 1'b0;
      checks++;
      if (regwrite_o !== 1'b1 || rd_o !== 5'd5) begin
         errors++;
         $display("FAIL alu_latency: got we=%b rd=%0d, required we=1 rd=5", regwrite_o, rd_o);
      end
      step();
      checks++;
      if (regwrite_o !== 1'b0) begin
         errors++;
         $display("FAIL alu_pulse_end: got we=%b, required 0", regwrite_o);
      end
   endtask

   task automatic test_back_to_back();
      mem_valid_i    = 1'b1;
      mem_wbsel_i    = 2'b00;
      mem_regwrite_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         mem_rd_i  = 5'(i);
         mem_alu_i = 32'hA000_0000 + 32'(i);
         exp_q.push_back('{5'(i), 32'hA000_0000 + 32'(i)});
         step();
         checks++;
         if (mem_ready_o !== 1'b1 || regwrite_o !== 1'b1 || rd_o !== 5'(i)) begin
            errors++;
            $display("FAIL b2b_%0d: got rdy=%b we=%b rd=%0d, required rdy=1 we=1 rd=%0d",
                     i, mem_ready_o, regwrite_o, rd_o, i);
         end
      end
      mem_valid_i = 1'b0;
      step();
      checks++;
      if (regwrite_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got we=%b, required 0", regwrite_o);
      end
   endtask

   task automatic test_load(input logic [2:0] f3, input logic [1:0] lo,
                            input logic [31:0] rdata, input logic [31:0] expv);
      mem_valid_i    = 1'b1;
      mem_wbsel_i    = 2'b01;
      mem_rd_i       = 5'd7;
      mem_regwrite_i = 1'b1;
      mem_funct3_i   = f3;
      mem_addr_lo_i  = lo;
      mem_alu_i      = 32'h5555_5555;
      dmem_rvalid_i  = 1'b1;
      dmem_rdata_i   = 32'hFFFF_FFFF;
      exp_q.push_back('{5'd7, expv});
      step();
      mem_valid_i   = 1'b0;
      dmem_rvalid_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (mem_ready_o !== 1'b0 || regwrite_o !== 1'b0) begin
            errors++;
            $display("FAIL load_wait_f3_%0d: got rdy=%b we=%b, required rdy=0 we=0",
                     f3, mem_ready_o, regwrite_o);
         end
         step();
      end
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      step();
      dmem_rvalid_i = 1'b0;
      checks++;
      if (regwrite_o !== 1'b1 || wd_o !== expv) begin
         errors++;
         $display("FAIL load_data_f3_%0d: got we=%b wd=%h, required we=1 wd=%h", f3, regwrite_o, wd_o, expv);
      end
      step();
   endtask

   task automatic test_rd0_pc4();
      logic [63:0] r0;
      r0 = 64'd0;
`ifdef WB_RETIRE_CNT_EN
      r0 = retire_cnt_o;
`endif
      mem_valid_i    = 1'b1;
      mem_wbsel_i    = 2'b10;
      mem_rd_i       = 5'd0;
      mem_regwrite_i = 1'b1;
      mem_pc4_i      = 32'h0000_0100;
      mem_alu_i      = 32'hAAAA_AAAA;
      step();
      mem_valid_i = 1'b0;
      checks++;
      if (regwrite_o !== 1'b0 || wd_o !== 32'h0000_0100 || rd_o !== 5'd0) begin
         errors++;
         $display("FAIL rd0_pc4: got we=%b rd=%0d wd=%h, required we=0 rd=0 wd=00000100",
                  regwrite_o, rd_o, wd_o);
      end
      step();
`ifdef WB_RETIRE_CNT_EN
      checks++;
      if (retire_cnt_o !== r0 + 64'd1) begin
         errors++;
         $display("FAIL retire_inc: got %0d, required %0d", retire_cnt_o, r0 + 64'd1);
      end
`endif
      checks++;
      if (regwrite_o !== 1'b0) begin
         errors++;
         $display("FAIL rd0_after: got we=%b, required 0", regwrite_o);
      end
   endtask

   task automatic test_timeout();
      int first;
      int pulses;
      int writes;
      logic [63:0] r0;
      first  = 0;
      pulses = 0;
      writes = 0;
      r0     = 64'd0;
`ifdef WB_RETIRE_CNT_EN
      r0 = retire_cnt_o;
`endif
      mem_valid_i    = 1'b1;
      mem_wbsel_i    = 2'b01;
      mem_rd_i       = 5'd9;
      mem_regwrite_i = 1'b1;
      mem_funct3_i   = 3'b010;
      step();
      mem_valid_i = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 6) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = 32'h1111_2222;
         end else begin
            dmem_rvalid_i = 1'b0;
         end
         step();
         if (err_o === 1'b1) begin
            pulses++;
            if (first == 0) first = c;
            checks++;
            if (mem_ready_o !== 1'b1) begin
               errors++;
               $display("FAIL timeout_ready: got %b, required 1", mem_ready_o);
            end
         end
         if (regwrite_o === 1'b1) writes++;
      end
      dmem_rvalid_i = 1'b0;
      checks++;
      if (first != 4 || pulses != 1 || writes != 0) begin
         errors++;
         $display("FAIL timeout: got err_cycle=%0d pulses=%0d writes=%0d, required 4 1 0", first, pulses, writes);
      end
`ifdef WB_RETIRE_CNT_EN
      checks++;
      if (retire_cnt_o !== r0) begin
         errors++;
         $display("FAIL timeout_retire: got %0d, required %0d", retire_cnt_o, r0);
      end
`endif
   endtask

   task automatic test_timeout_priority();
      mem_valid_i    = 1'b1;
      mem_wbsel_i    = 2'b01;
      mem_rd_i       = 5'd10;
      mem_regwrite_i = 1'b1;
      mem_funct3_i   = 3'b010;
      exp_q.push_back('{5'd10, 32'h0BAD_F00D});
      step();
      mem_valid_i = 1'b0;
      step();
      step();
      step();
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h0BAD_F00D;
      step();
      dmem_rvalid_i = 1'b0;
      checks++;
      if (regwrite_o !== 1'b1 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL last_count_rvalid: got we=%b err=%b, required we=1 err=0", regwrite_o, err_o);
      end
      step();
   endtask

   task automatic test_reset_in_wait();
      mem_valid_i    = 1'b1;
      mem_wbsel_i    = 2'b01;
      mem_rd_i       = 5'd3;
      mem_regwrite_i = 1'b1;
      mem_funct3_i   = 3'b010;
      step();
      mem_valid_i = 1'b0;
      step();
      reset_i = 1'b0;
      step();
      checks++;
      if ({regwrite_o, rd_o, wd_o, err_o, mem_ready_o} !== 40'd0) begin
         errors++;
         $display("FAIL wait_reset: got we=%b rd=%0d wd=%h err=%b rdy=%b, required all 0",
                  regwrite_o, rd_o, wd_o, err_o, mem_ready_o);
      end
      reset_i = 1'b1;
      step();
      checks++;
      if (mem_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL wait_reset_ready: got %b, required 1", mem_ready_o);
      end
      mem_valid_i = 1'b1;
      exp_q.push_back('{5'd3, 32'hDEAD_BEEF});
      step();
      mem_valid_i   = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hDEAD_BEEF;
      step();
      dmem_rvalid_i = 1'b0;
      checks++;
      if (regwrite_o !== 1'b1 || wd_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_lw: got we=%b wd=%h err=%b, required we=1 wd=deadbeef err=0",
                  regwrite_o, wd_o, err_o);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_load(3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
      test_load(3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080);
      test_load(3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
      test_load(3'b101, 2'd3, 32'h8001_0000, 32'h0000_8001);
      test_load(3'b001, 2'd1, 32'h1234_F00F, 32'hFFFF_F00F);
      test_load(3'b011, 2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE);
      test_rd0_pc4();
      test_timeout();
      test_timeout_priority();
      test_reset_in_wait();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending writes, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
